// File: rtl/seq_bank_pkg.sv
// -----------------------------------------------------------------------------
// seq_bank_pkg
// Shared definitions for the score-bank sequence loader:
//   - 2-bit nucleotide codes
//   - header flag bit positions inside the packed bank word
//   - loader FSM state encoding
//   - packed bank word width helper
// No ports (package).
// -----------------------------------------------------------------------------
package seq_bank_pkg;

  // Nucleotide encoding; T doubles as the pad value for unfilled slots.
  localparam logic [1:0] NT_A = 2'b10;
  localparam logic [1:0] NT_G = 2'b11;
  localparam logic [1:0] NT_T = 2'b00;
  localparam logic [1:0] NT_C = 2'b01;

  // Flag positions at the head of the packed word.
  localparam int unsigned TGT_BIT = 0;
  localparam int unsigned QRY_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PEN        = 3'd1,
    ST_FILL       = 3'd2,
    ST_ISSUE_WAIT = 3'd3,
    ST_ISSUE      = 3'd4
  } state_e;

  // Packed word: two flags, ID, length, then 2 bits per base.
  function automatic int unsigned calc_in_width(input int unsigned id_w,
                                                input int unsigned len_w,
                                                input int unsigned tgt_len);
    return 2 + id_w + len_w + 2 * tgt_len;
  endfunction

endpackage

// File: rtl/seq_bank_loader_if.sv
// -----------------------------------------------------------------------------
// seq_bank_loader_if
// Bundles the loader's stream inputs (header, base beats, penalties) and its
// score-bank side (bank_full, load strobes, packed word, penalties).
// Modports:
//   master : upstream source / bank model (drives valids, data, bank_full)
//   slave  : the loader (drives readies, strobes, data_out, penalties_out)
// -----------------------------------------------------------------------------
interface seq_bank_loader_if
  import seq_bank_pkg::*;
#(
  parameter int unsigned ID_WIDTH      = 48,
  parameter int unsigned LEN_WIDTH     = 12,
  parameter int unsigned TARGET_LENGTH = 128,
  parameter int unsigned SCORE_WIDTH   = 12,
  parameter int unsigned BEAT_BASES    = 4
);

  localparam int unsigned IN_WIDTH = calc_in_width(ID_WIDTH, LEN_WIDTH, TARGET_LENGTH);

  logic                     hdr_valid;
  logic                     hdr_ready;
  logic                     hdr_is_query;
  logic [ID_WIDTH-1:0]      hdr_id;
  logic [LEN_WIDTH-1:0]     hdr_len;

  logic                     beat_valid;
  logic                     beat_ready;
  logic [2*BEAT_BASES-1:0]  beat_data;

  logic                     pen_valid;
  logic                     pen_ready;
  logic [4*SCORE_WIDTH-1:0] pen_data;

  logic                     bank_full;
  logic                     ld_sequence;
  logic                     ld_penalties;
  logic [0:IN_WIDTH-1]      data_out;
  logic [4*SCORE_WIDTH-1:0] penalties_out;

  modport master (
    output hdr_valid, hdr_is_query, hdr_id, hdr_len,
    output beat_valid, beat_data,
    output pen_valid, pen_data,
    output bank_full,
    input  hdr_ready, beat_ready, pen_ready,
    input  ld_sequence, ld_penalties, data_out, penalties_out
  );

  modport slave (
    input  hdr_valid, hdr_is_query, hdr_id, hdr_len,
    input  beat_valid, beat_data,
    input  pen_valid, pen_data,
    input  bank_full,
    output hdr_ready, beat_ready, pen_ready,
    output ld_sequence, ld_penalties, data_out, penalties_out
  );

endinterface

// File: rtl/seq_pack_slots.sv
// -----------------------------------------------------------------------------
// seq_pack_slots
// Base slot register and fill counter for one record.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   clear           empty all slots and zero the counter (new header)
//   wr_en           accept one beat into the slots at the current count
//   eff_len         effective record length (bases)
//   beat_data       BEAT_BASES bases, base j at [2j+1:2j]
//   slots           base k at [2k+1:2k]
//   cnt             bases written so far
//   last_c          this write brings cnt up to eff_len (combinational)
// -----------------------------------------------------------------------------
module seq_pack_slots
  import seq_bank_pkg::*;
#(
  parameter int unsigned TARGET_LENGTH = 128,
  parameter int unsigned BEAT_BASES    = 4,
  parameter int unsigned CNT_WIDTH     = $clog2(TARGET_LENGTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [CNT_WIDTH-1:0]       eff_len,
  input  logic [2*BEAT_BASES-1:0]    beat_data,
  output logic [2*TARGET_LENGTH-1:0] slots,
  output logic [CNT_WIDTH-1:0]       cnt,
  output logic                       last_c
);

  logic [2*TARGET_LENGTH-1:0] slots_q, slots_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]       room_c;
  logic [CNT_WIDTH-1:0]       n_wr_c;

  // Masked write: only the first min(BEAT_BASES, remaining) beat bases land.
  always_comb begin
    slots_d = slots_q;
    cnt_d   = cnt_q;
    room_c  = eff_len - cnt_q;
    n_wr_c  = (room_c > CNT_WIDTH'(BEAT_BASES)) ? CNT_WIDTH'(BEAT_BASES) : room_c;
    if (clear) begin
      slots_d = {TARGET_LENGTH{NT_T}};
      cnt_d   = '0;
    end else if (wr_en) begin
      for (int unsigned k = 0; k < TARGET_LENGTH; k++) begin
        for (int unsigned j = 0; j < BEAT_BASES; j++) begin
          if ((k == 32'(cnt_q) + j) && (j < 32'(n_wr_c))) begin
            slots_d[2*k +: 2] = beat_data[2*j +: 2];
          end
        end
      end
      cnt_d = cnt_q + n_wr_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slots_q <= '0;
      cnt_q   <= '0;
    end else begin
      slots_q <= slots_d;
      cnt_q   <= cnt_d;
    end
  end

  assign slots  = slots_q;
  assign cnt    = cnt_q;
  assign last_c = wr_en && !clear && (cnt_d == eff_len);

endmodule

// File: rtl/seq_bank_loader.sv
// -----------------------------------------------------------------------------
// seq_bank_loader
// Transmit side of the score-bank sequence load interface. Takes a record
// header then base beats, packs them into one bank word
// {target flag, query flag, ID, length, bases} and issues a one-cycle
// ld_sequence (target records wait out bank_full). Penalty requests are
// registered and announced with a one-cycle ld_penalties.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   bus (slave)     header / beat / penalty streams and score-bank side
//   len_err         sticky: a header longer than TARGET_LENGTH was seen
//   busy            FSM not idle
// Optional (SEQ_BANK_LOADER_STATS_EN defined):
//   tgt_count, qry_count   ld_sequence count per record type
//   stall_cycles           ISSUE_WAIT cycles spent with bank_full high
// -----------------------------------------------------------------------------
module seq_bank_loader
  import seq_bank_pkg::*;
#(
  parameter int unsigned ID_WIDTH      = 48,
  parameter int unsigned LEN_WIDTH     = 12,
  parameter int unsigned TARGET_LENGTH = 128,
  parameter int unsigned SCORE_WIDTH   = 12,
  parameter int unsigned BEAT_BASES    = 4
) (
  input  logic                clk,
  input  logic                rst,
  seq_bank_loader_if.slave    bus,
  output logic                len_err,
  output logic                busy
`ifdef SEQ_BANK_LOADER_STATS_EN
  ,
  output logic [31:0]         tgt_count,
  output logic [31:0]         qry_count,
  output logic [31:0]         stall_cycles
`endif
);

  localparam int unsigned IN_WIDTH  = calc_in_width(ID_WIDTH, LEN_WIDTH, TARGET_LENGTH);
  localparam int unsigned CNT_WIDTH = $clog2(TARGET_LENGTH + 1);
  localparam int unsigned BASE_OFF  = 2 + ID_WIDTH + LEN_WIDTH;
  localparam int unsigned PEN_W     = 4 * SCORE_WIDTH;

  state_e                     state_q, state_d;
  logic                       is_query_q, is_query_d;
  logic [ID_WIDTH-1:0]        id_q, id_d;
  logic [LEN_WIDTH-1:0]       len_q, len_d;
  logic [CNT_WIDTH-1:0]       eff_len_q, eff_len_d;
  logic                       ld_seq_q, ld_seq_d;
  logic                       ld_pen_q, ld_pen_d;
  logic [PEN_W-1:0]           pen_q, pen_d;
  logic [0:IN_WIDTH-1]        data_q, data_d;
  logic                       len_err_q, len_err_d;
  logic                       busy_q, busy_d;

  logic                       hdr_ready_c, beat_ready_c, pen_ready_c;
  logic                       hdr_acc_c, beat_acc_c, pen_acc_c;
  logic                       hdr_over_c;
  logic [CNT_WIDTH-1:0]       hdr_eff_c;
  logic [0:IN_WIDTH-1]        word_c;
  logic [2*TARGET_LENGTH-1:0] slots;
  logic [CNT_WIDTH-1:0]       cnt;
  logic                       last_c;

  // Readies are held low while reset is applied; penalties beat headers in IDLE.
  assign pen_ready_c  = rst && (state_q == ST_IDLE);
  assign hdr_ready_c  = rst && (state_q == ST_IDLE) && !bus.pen_valid;
  assign beat_ready_c = rst && (state_q == ST_FILL);
  assign pen_acc_c    = bus.pen_valid  && pen_ready_c;
  assign hdr_acc_c    = bus.hdr_valid  && hdr_ready_c;
  assign beat_acc_c   = bus.beat_valid && beat_ready_c;

  // Over-long records are truncated to the slot count.
  assign hdr_over_c = bus.hdr_len > LEN_WIDTH'(TARGET_LENGTH);
  assign hdr_eff_c  = hdr_over_c ? CNT_WIDTH'(TARGET_LENGTH) : CNT_WIDTH'(bus.hdr_len);

  seq_pack_slots #(
    .TARGET_LENGTH (TARGET_LENGTH),
    .BEAT_BASES    (BEAT_BASES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_slots (
    .clk       (clk),
    .rst       (rst),
    .clear     (hdr_acc_c),
    .wr_en     (beat_acc_c),
    .eff_len   (eff_len_q),
    .beat_data (bus.beat_data),
    .slots     (slots),
    .cnt       (cnt),
    .last_c    (last_c)
  );

  // Bank word layout; multi-bit fields put their MSB at the lowest index.
  always_comb begin
    word_c                          = '0;
    word_c[TGT_BIT]                 = ~is_query_q;
    word_c[QRY_BIT]                 = is_query_q;
    word_c[2 +: ID_WIDTH]           = id_q;
    word_c[2+ID_WIDTH +: LEN_WIDTH] = len_q;
    for (int unsigned k = 0; k < TARGET_LENGTH; k++) begin
      word_c[BASE_OFF+2*k +: 2] = slots[2*k +: 2];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    is_query_d = is_query_q;
    id_d       = id_q;
    len_d      = len_q;
    eff_len_d  = eff_len_q;
    pen_d      = pen_q;
    data_d     = data_q;
    len_err_d  = len_err_q;
    ld_seq_d   = 1'b0;
    ld_pen_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pen_acc_c) begin
          pen_d    = bus.pen_data;
          ld_pen_d = 1'b1;
          state_d  = ST_PEN;
        end else if (hdr_acc_c) begin
          is_query_d = bus.hdr_is_query;
          id_d       = bus.hdr_id;
          len_d      = hdr_over_c ? LEN_WIDTH'(TARGET_LENGTH) : bus.hdr_len;
          eff_len_d  = hdr_eff_c;
          len_err_d  = len_err_q | hdr_over_c;
          state_d    = (hdr_eff_c == '0) ? ST_ISSUE_WAIT : ST_FILL;
        end
      end
      ST_PEN:  state_d = ST_IDLE;
      ST_FILL: begin
        if (last_c) state_d = ST_ISSUE_WAIT;
      end
      ST_ISSUE_WAIT: begin
        if (is_query_q || !bus.bank_full) begin
          data_d   = word_c;
          ld_seq_d = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

`ifdef SEQ_BANK_LOADER_STATS_EN
  logic [31:0] tgt_q, tgt_d, qry_q, qry_d, stall_q, stall_d;

  // Counters step in the same edge that raises ld_sequence.
  always_comb begin
    tgt_d   = tgt_q;
    qry_d   = qry_q;
    stall_d = stall_q;
    if (ld_seq_d && is_query_q)  qry_d = qry_q + 32'd1;
    if (ld_seq_d && !is_query_q) tgt_d = tgt_q + 32'd1;
    if ((state_q == ST_ISSUE_WAIT) && bus.bank_full) stall_d = stall_q + 32'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      is_query_q <= 1'b0;
      id_q       <= '0;
      len_q      <= '0;
      eff_len_q  <= '0;
      ld_seq_q   <= 1'b0;
      ld_pen_q   <= 1'b0;
      pen_q      <= '0;
      data_q     <= '0;
      len_err_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SEQ_BANK_LOADER_STATS_EN
      tgt_q      <= '0;
      qry_q      <= '0;
      stall_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      is_query_q <= is_query_d;
      id_q       <= id_d;
      len_q      <= len_d;
      eff_len_q  <= eff_len_d;
      ld_seq_q   <= ld_seq_d;
      ld_pen_q   <= ld_pen_d;
      pen_q      <= pen_d;
      data_q     <= data_d;
      len_err_q  <= len_err_d;
      busy_q     <= busy_d;
`ifdef SEQ_BANK_LOADER_STATS_EN
      tgt_q      <= tgt_d;
      qry_q      <= qry_d;
      stall_q    <= stall_d;
`endif
    end
  end

  assign bus.hdr_ready     = hdr_ready_c;
  assign bus.beat_ready    = beat_ready_c;
  assign bus.pen_ready     = pen_ready_c;
  assign bus.ld_sequence   = ld_seq_q;
  assign bus.ld_penalties  = ld_pen_q;
  assign bus.data_out      = data_q;
  assign bus.penalties_out = pen_q;
  assign len_err           = len_err_q;
  assign busy              = busy_q;
`ifdef SEQ_BANK_LOADER_STATS_EN
  assign tgt_count    = tgt_q;
  assign qry_count    = qry_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_seq_bank_loader.sv
// -----------------------------------------------------------------------------
// tb_seq_bank_loader
// Directed bench for seq_bank_loader with TARGET_LENGTH=8 (78-bit bank word).
// Inputs change 1 time unit after the rising edge; outputs are read there too.
// -----------------------------------------------------------------------------
module tb_seq_bank_loader;

  localparam int unsigned TL  = 8;
  localparam int unsigned IDW = 48;
  localparam int unsigned LW  = 12;
  localparam int unsigned BO  = 2 + IDW + LW;  // first base bit

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic len_err, busy;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_bank_loader_if #(.TARGET_LENGTH(TL)) bus ();

`ifdef SEQ_BANK_LOADER_STATS_EN
  logic [31:0] tgt_count, qry_count, stall_cycles;
`endif

  seq_bank_loader #(.TARGET_LENGTH(TL)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .len_err      (len_err),
    .busy         (busy)
`ifdef SEQ_BANK_LOADER_STATS_EN
    ,
    .tgt_count    (tgt_count),
    .qry_count    (qry_count),
    .stall_cycles (stall_cycles)
`endif
  );

  // Field views of the packed word.
  logic [1:0]    f_flags;
  logic [IDW-1:0] f_id;
  logic [LW-1:0] f_len;
  logic [2*TL-1:0] f_bases;
  assign f_flags = bus.data_out[0:1];
  assign f_id    = bus.data_out[2 +: IDW];
  assign f_len   = bus.data_out[2+IDW +: LW];
  assign f_bases = bus.data_out[BO +: 2*TL];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic q, input logic [IDW-1:0] id, input logic [LW-1:0] len);
    bus.hdr_valid    = 1'b1;
    bus.hdr_is_query = q;
    bus.hdr_id       = id;
    bus.hdr_len      = len;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.hdr_valid = 1'b1; bus.pen_valid = 1'b1; bus.beat_valid = 1'b1;
    step();
    total++; if (bus.ld_sequence !== 1'b0) begin bad++; $display("FAIL reset_ld_seq got=%b want=0", bus.ld_sequence); end
    total++; if (bus.ld_penalties !== 1'b0) begin bad++; $display("FAIL reset_ld_pen got=%b want=0", bus.ld_penalties); end
    total++; if ({len_err, busy} !== 2'b00) begin bad++; $display("FAIL reset_err_busy got=%b want=00", {len_err, busy}); end
    total++; if (bus.data_out !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", bus.data_out); end
    total++; if (bus.penalties_out !== '0) begin bad++; $display("FAIL reset_pen got=%h want=0", bus.penalties_out); end
    total++; if ({bus.hdr_ready, bus.beat_ready, bus.pen_ready} !== 3'b000) begin
      bad++; $display("FAIL reset_readies got=%b want=000", {bus.hdr_ready, bus.beat_ready, bus.pen_ready}); end
    bus.hdr_valid = 1'b0; bus.pen_valid = 1'b0; bus.beat_valid = 1'b0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_penalty();
    bus.pen_valid = 1'b1;
    bus.pen_data  = 48'h001_002_003_004;
    send_hdr(1'b1, 48'd9, 12'd0);
    #1;
    total++; if ({bus.pen_ready, bus.hdr_ready} !== 2'b10) begin
      bad++; $display("FAIL pen_arb got=%b want=10", {bus.pen_ready, bus.hdr_ready}); end
    step();
    bus.pen_valid = 1'b0;
    bus.pen_data  = '0;
    #1;
    total++; if (bus.ld_penalties !== 1'b1) begin bad++; $display("FAIL pen_strobe got=%b want=1", bus.ld_penalties); end
    total++; if (bus.penalties_out !== 48'h001_002_003_004) begin
      bad++; $display("FAIL pen_value got=%h want=001002003004", bus.penalties_out); end
    total++; if (bus.hdr_ready !== 1'b0) begin bad++; $display("FAIL pen_hdr_blocked got=%b want=0", bus.hdr_ready); end
    step();
    total++; if (bus.ld_penalties !== 1'b0) begin bad++; $display("FAIL pen_one_cycle got=%b want=0", bus.ld_penalties); end
    total++; if (bus.penalties_out !== 48'h001_002_003_004) begin
      bad++; $display("FAIL pen_hold got=%h want=001002003004", bus.penalties_out); end
    total++; if (bus.hdr_ready !== 1'b1) begin bad++; $display("FAIL pen_idle_hdr got=%b want=1", bus.hdr_ready); end
    bus.hdr_valid = 1'b0;
    step();
  endtask

  task automatic test_query();
    send_hdr(1'b1, 48'd5, 12'd6);
    step();
    bus.hdr_valid = 1'b0;
    bus.beat_valid = 1'b1; bus.beat_data = 8'hE4;
    #1;
    total++; if (bus.beat_ready !== 1'b1) begin bad++; $display("FAIL q_beat_ready got=%b want=1", bus.beat_ready); end
    step();
    bus.beat_data = 8'h0B;
    step();
    bus.beat_valid = 1'b0;
    total++; if (bus.ld_sequence !== 1'b0) begin bad++; $display("FAIL q_ld_early got=%b want=0", bus.ld_sequence); end
    step();
    total++; if (bus.ld_sequence !== 1'b1) begin bad++; $display("FAIL q_ld_latency got=%b want=1", bus.ld_sequence); end
    total++; if (f_flags !== 2'b01) begin bad++; $display("FAIL q_flags got=%b want=01", f_flags); end
    total++; if (f_id !== 48'd5) begin bad++; $display("FAIL q_id got=%h want=5", f_id); end
    total++; if (f_len !== 12'd6) begin bad++; $display("FAIL q_len got=%0d want=6", f_len); end
    total++; if (f_bases !== 16'h1BE0) begin bad++; $display("FAIL q_bases got=%h want=1be0", f_bases); end
    step();
    total++; if (bus.ld_sequence !== 1'b0) begin bad++; $display("FAIL q_ld_one_cycle got=%b want=0", bus.ld_sequence); end
    total++; if (f_bases !== 16'h1BE0) begin bad++; $display("FAIL q_data_hold got=%h want=1be0", f_bases); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL q_idle got=%b want=0", busy); end
  endtask

  task automatic test_target_bank_full();
    bus.bank_full = 1'b1;
    send_hdr(1'b0, 48'hABCDEF, 12'd8);
    step();
    bus.hdr_valid = 1'b0;
    bus.beat_valid = 1'b1; bus.beat_data = 8'h1B;
    step();
    bus.beat_data = 8'hE4;
    step();
    bus.beat_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.ld_sequence !== 1'b0) begin bad++; $display("FAIL t_ld_while_full cyc=%0d got=%b want=0", i, bus.ld_sequence); end
      step();
    end
    bus.bank_full = 1'b0;
    total++; if (bus.ld_sequence !== 1'b0) begin bad++; $display("FAIL t_ld_drop_cycle got=%b want=0", bus.ld_sequence); end
    step();
    total++; if (bus.ld_sequence !== 1'b1) begin bad++; $display("FAIL t_ld_after_drop got=%b want=1", bus.ld_sequence); end
    total++; if (f_flags !== 2'b10) begin bad++; $display("FAIL t_flags got=%b want=10", f_flags); end
    total++; if (f_id !== 48'hABCDEF) begin bad++; $display("FAIL t_id got=%h want=abcdef", f_id); end
    total++; if (f_len !== 12'd8) begin bad++; $display("FAIL t_len got=%0d want=8", f_len); end
    total++; if (f_bases !== 16'hE41B) begin bad++; $display("FAIL t_bases got=%h want=e41b", f_bases); end
    step();
  endtask

  task automatic test_zero_len();
    send_hdr(1'b0, 48'd7, 12'd0);
    step();
    bus.hdr_valid = 1'b0;
    bus.beat_valid = 1'b1; bus.beat_data = 8'hFF;
    #1;
    total++; if (bus.beat_ready !== 1'b0) begin bad++; $display("FAIL z_beat_ready got=%b want=0", bus.beat_ready); end
    total++; if (bus.ld_sequence !== 1'b0) begin bad++; $display("FAIL z_ld_early got=%b want=0", bus.ld_sequence); end
    step();
    total++; if (bus.ld_sequence !== 1'b1) begin bad++; $display("FAIL z_ld_latency got=%b want=1", bus.ld_sequence); end
    total++; if (bus.beat_ready !== 1'b0) begin bad++; $display("FAIL z_beat_ready2 got=%b want=0", bus.beat_ready); end
    total++; if (f_len !== 12'd0) begin bad++; $display("FAIL z_len got=%0d want=0", f_len); end
    total++; if (f_bases !== 16'h0000) begin bad++; $display("FAIL z_bases got=%h want=0", f_bases); end
    total++; if (f_flags !== 2'b10) begin bad++; $display("FAIL z_flags got=%b want=10", f_flags); end
    bus.beat_valid = 1'b0;
    step();
  endtask

  task automatic test_len_err();
    logic [7:0] pat [3];
    int acc;
    int lds;
    logic [LW-1:0]   cap_len;
    logic [2*TL-1:0] cap_bases;
    pat = '{8'hFF, 8'h55, 8'hAA};
    acc = 0; lds = 0; cap_len = '0; cap_bases = '0;
    total++; if (len_err !== 1'b0) begin bad++; $display("FAIL le_before got=%b want=0", len_err); end
    send_hdr(1'b1, 48'd3, 12'd20);
    step();
    bus.hdr_valid = 1'b0;
    total++; if (len_err !== 1'b1) begin bad++; $display("FAIL le_set got=%b want=1", len_err); end
    for (int c = 0; c < 8; c++) begin
      bus.beat_valid = 1'b1;
      bus.beat_data  = pat[(acc < 3) ? acc : 2];
      #1;
      if (bus.beat_ready) acc++;
      if (bus.ld_sequence) begin lds++; cap_len = f_len; cap_bases = f_bases; end
      step();
    end
    bus.beat_valid = 1'b0;
    total++; if (acc !== 2) begin bad++; $display("FAIL le_beats got=%0d want=2", acc); end
    total++; if (lds !== 1) begin bad++; $display("FAIL le_strobes got=%0d want=1", lds); end
    total++; if (cap_len !== 12'd8) begin bad++; $display("FAIL le_len_field got=%0d want=8", cap_len); end
    total++; if (cap_bases !== 16'hFF55) begin bad++; $display("FAIL le_bases got=%h want=ff55", cap_bases); end
    // A following short record leaves the sticky flag set.
    send_hdr(1'b1, 48'd4, 12'd0);
    step();
    bus.hdr_valid = 1'b0;
    step(); step();
    total++; if (len_err !== 1'b1) begin bad++; $display("FAIL le_sticky got=%b want=1", len_err); end
  endtask

  task automatic test_reset_mid_fill();
    int lds;
    lds = 0;
    send_hdr(1'b1, 48'h11, 12'd8);
    step();
    bus.hdr_valid = 1'b0;
    bus.beat_valid = 1'b1; bus.beat_data = 8'hFF;
    step();
    bus.beat_valid = 1'b0;
    rst = 1'b0;
    step();
    total++; if ({busy, bus.ld_sequence, len_err} !== 3'b000) begin
      bad++; $display("FAIL rm_reset got=%b want=000", {busy, bus.ld_sequence, len_err}); end
    total++; if (bus.data_out !== '0) begin bad++; $display("FAIL rm_data got=%h want=0", bus.data_out); end
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (bus.ld_sequence) lds++;
      step();
    end
    total++; if (lds !== 0) begin bad++; $display("FAIL rm_no_strobe got=%0d want=0", lds); end
    send_hdr(1'b1, 48'h22, 12'd2);
    step();
    bus.hdr_valid = 1'b0;
    bus.beat_valid = 1'b1; bus.beat_data = 8'hE4;
    step();
    bus.beat_valid = 1'b0;
    step();
    total++; if (bus.ld_sequence !== 1'b1) begin bad++; $display("FAIL rm_ld got=%b want=1", bus.ld_sequence); end
    total++; if (f_bases !== 16'h1000) begin bad++; $display("FAIL rm_clean_bases got=%h want=1000", f_bases); end
    total++; if (f_id !== 48'h22) begin bad++; $display("FAIL rm_id got=%h want=22", f_id); end
    step();
  endtask

  initial begin
    bus.hdr_valid = 1'b0; bus.hdr_is_query = 1'b0; bus.hdr_id = '0; bus.hdr_len = '0;
    bus.beat_valid = 1'b0; bus.beat_data = '0;
    bus.pen_valid = 1'b0; bus.pen_data = '0;
    bus.bank_full = 1'b0;
    #1;
    test_reset();
    test_penalty();
    test_query();
    test_target_bank_full();
    test_zero_len();
    test_len_err();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
